sound_scheduler: RTL and testbench

Time-shares the single buzzer tone generator among up to N_REQ sound requesters: the logo/ball dynamics, paddles and game-state logic. Each requester posts a one-cycle event with a 2-bit sound code. The block latches pending events and grants them round-robin. Each granted sound is played for a fixed tone time followed by a silent gap, and the block drives the `code_sound`/`mute` pair that the tone generator consumes.

---
 rtl/sound_pkg.sv | 23 ++
 rtl/rr_arbiter.sv | 34 +++
 rtl/sound_scheduler.sv | 165 ++++++++++++++++
 tb/tb_sound_scheduler.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/sound_pkg.sv
// Shared definitions for the buzzer sound scheduler: sound codes, FSM states
// and the counter-width helper.
package sound_pkg;

    localparam logic [1:0] SND_PING = 2'd0;
    localparam logic [1:0] SND_PONG = 2'd1;
    localparam logic [1:0] SND_GO   = 2'd2;
    localparam logic [1:0] SND_STOP = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_GAP  = 2'd2
    } sched_state_t;

    // Wide enough to hold the larger of the two phase lengths.
    function automatic int cntWidth(input int toneCycles, input int gapCycles);
        int larger;
        larger = (toneCycles > gapCycles) ? toneCycles : gapCycles;
        return $clog2(larger + 1);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: searches the pending vector starting one
// position after the pointer and returns the first hit as one-hot and index.
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] i_pending,
    input  logic [IDX_W-1:0] i_ptr,
    output logic [N_REQ-1:0] o_grant,
    output logic [IDX_W-1:0] o_index,
    output logic             o_valid
);

    logic w_found;
    int   w_idx;

    always_comb begin
        o_grant = '0;
        o_index = '0;
        w_found = 1'b0;
        w_idx   = 0;
        for (int k = 1; k <= N_REQ; k++) begin
            w_idx = (int'(i_ptr) + k) % N_REQ;
            if (!w_found && i_pending[w_idx]) begin
                w_found        = 1'b1;
                o_grant[w_idx] = 1'b1;
                o_index        = w_idx[IDX_W-1:0];
            end
        end
    end

    assign o_valid = w_found;

endmodule

// File: rtl/sound_scheduler.sv
// Time-shares the buzzer tone generator among N_REQ requesters: latches one
// pending sound per requester, grants round-robin, plays tone then silent gap.
module sound_scheduler
    import sound_pkg::*;
#(
    parameter int N_REQ       = 4,
    parameter int TONE_CYCLES = 1_200_000,
    parameter int GAP_CYCLES  = 120_000
) (
    input  logic                 clk,
    input  logic                 clr,
    input  logic                 enable,
    input  logic [N_REQ-1:0]     req,
    input  logic [2*N_REQ-1:0]   req_code,
    output logic [1:0]           code_sound,
    output logic                 mute,
    output logic [N_REQ-1:0]     grant,
    output logic                 busy
);

    localparam int IDX_W = $clog2(N_REQ);
    localparam int CNT_W = cntWidth(TONE_CYCLES, GAP_CYCLES);

    localparam logic [CNT_W-1:0] TONE_LOAD = CNT_W'(TONE_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    // Pointer starts at the last requester so requester 0 is searched first.
    localparam logic [IDX_W-1:0] PTR_RESET = IDX_W'(N_REQ - 1);

    logic [N_REQ-1:0]      r_pending;
    logic [N_REQ-1:0][1:0] r_codes;

    sched_state_t     r_state, w_stateNext;
    logic [CNT_W-1:0] r_cnt, w_cntNext;
    logic [IDX_W-1:0] r_ptr, w_ptrNext;
    logic [1:0]       r_code, w_codeNext;
    logic             r_mute, w_muteNext;
    logic [N_REQ-1:0] r_grant, w_grantNext;
    logic             r_busy, w_busyNext;

    logic [N_REQ-1:0] w_winOneHot;
    logic [IDX_W-1:0] w_winIdx;
    logic             w_anyPending;
    logic             w_take;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_arb (
        .i_pending (r_pending),
        .i_ptr     (r_ptr),
        .o_grant   (w_winOneHot),
        .o_index   (w_winIdx),
        .o_valid   (w_anyPending)
    );

    // A fresh request beats the grant-clear so an event landing on its own
    // grant edge is kept for the next round.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_pending <= '0;
            r_codes   <= '0;
        end else begin
            for (int i = 0; i < N_REQ; i++) begin
                if (!enable) begin
                    r_pending[i] <= 1'b0;
                end else if (req[i]) begin
                    r_pending[i] <= 1'b1;
                    r_codes[i]   <= req_code[2*i +: 2];
                end else if (w_take && w_winOneHot[i]) begin
                    r_pending[i] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_ptr   <= PTR_RESET;
            r_code  <= SND_PING;
            r_mute  <= 1'b1;
            r_grant <= '0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_stateNext;
            r_cnt   <= w_cntNext;
            r_ptr   <= w_ptrNext;
            r_code  <= w_codeNext;
            r_mute  <= w_muteNext;
            r_grant <= w_grantNext;
            r_busy  <= w_busyNext;
        end
    end

    // Next-state and next-output logic; all outputs are registered above.
    always_comb begin
        w_stateNext = r_state;
        w_cntNext   = r_cnt;
        w_ptrNext   = r_ptr;
        w_codeNext  = r_code;
        w_muteNext  = 1'b1;
        w_grantNext = '0;
        w_busyNext  = r_busy;
        w_take      = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_busyNext = 1'b0;
                if (enable && w_anyPending) begin
                    w_take      = 1'b1;
                    w_stateNext = ST_PLAY;
                    w_cntNext   = TONE_LOAD;
                    w_ptrNext   = w_winIdx;
                    w_codeNext  = r_codes[w_winIdx];
                    w_muteNext  = 1'b0;
                    w_grantNext = w_winOneHot;
                    w_busyNext  = 1'b1;
                end
            end
            ST_PLAY: begin
                w_busyNext = 1'b1;
                if (r_cnt == '0) begin
                    w_stateNext = ST_GAP;
                    w_cntNext   = GAP_LOAD;
                    w_muteNext  = 1'b1;
                end else begin
                    w_cntNext  = r_cnt - CNT_ONE;
                    w_muteNext = 1'b0;
                end
            end
            ST_GAP: begin
                w_busyNext = 1'b1;
                if (r_cnt == '0) begin
                    w_stateNext = ST_IDLE;
                    w_cntNext   = '0;
                    w_busyNext  = 1'b0;
                end else begin
                    w_cntNext = r_cnt - CNT_ONE;
                end
            end
            default: begin
                w_stateNext = ST_IDLE;
                w_cntNext   = '0;
                w_busyNext  = 1'b0;
            end
        endcase

        // Disabling sound aborts any tone or gap on the next edge.
        if (!enable) begin
            w_stateNext = ST_IDLE;
            w_cntNext   = '0;
            w_muteNext  = 1'b1;
            w_busyNext  = 1'b0;
            w_grantNext = '0;
        end
    end

    assign code_sound = r_code;
    assign mute       = r_mute;
    assign grant      = r_grant;
    assign busy       = r_busy;

endmodule

// File: tb/tb_sound_scheduler.sv
// Scoreboard bench for sound_scheduler: stimulus pushes expected grants,
// a negedge monitor pops and compares them; window/reset checks are inline.
module tb_sound_scheduler;
    import sound_pkg::*;

    localparam int N = 4;
    localparam int T = 8;
    localparam int G = 2;

    logic       clk = 1'b0;
    logic       clr;
    logic       enable;
    logic [3:0] req;
    logic [7:0] req_code;
    logic [1:0] code_sound;
    logic       mute;
    logic [3:0] grant;
    logic       busy;

    typedef struct {
        logic [3:0] g;
        logic [1:0] code;
        int         cyc;
    } exp_t;

    exp_t expQ[$];
    exp_t monE;
    int   cyc = 0;
    int   nCompared = 0;
    int   nMismatched = 0;

    sound_scheduler #(
        .N_REQ       (N),
        .TONE_CYCLES (T),
        .GAP_CYCLES  (G)
    ) dut (
        .clk        (clk),
        .clr        (clr),
        .enable     (enable),
        .req        (req),
        .req_code   (req_code),
        .code_sound (code_sound),
        .mute       (mute),
        .grant      (grant),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        nCompared++;
        if (actual !== expected) begin
            nMismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic expectGrant(input logic [3:0] g, input logic [1:0] code, input int at);
        exp_t e;
        e.g    = g;
        e.code = code;
        e.cyc  = at;
        expQ.push_back(e);
    endtask

    // Drives a one-cycle request; stimCyc is the cycle count when driven, so
    // the request is sampled at edge stimCyc+1 and granted at edge stimCyc+2.
    task automatic applyStimulus(input logic [3:0] vec, input logic [7:0] codes,
                                 output int stimCyc);
        @(posedge clk);
        #1;
        req      = vec;
        req_code = codes;
        stimCyc  = cyc;
        @(posedge clk);
        #1;
        req = 4'b0000;
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (clr === 1'b0 && grant !== 4'b0000) begin
            if (expQ.size() == 0) begin
                checkOutput("unexpected_grant", 32'(grant), 32'd0);
            end else begin
                monE = expQ.pop_front();
                checkOutput("grant_vec", 32'(grant), 32'(monE.g));
                checkOutput("grant_code", 32'(code_sound), 32'(monE.code));
                checkOutput("grant_cycle", cyc, monE.cyc);
            end
        end
    end

    initial begin
        int c;
        int c2;
        logic anyBusy;

        clr      = 1'b1;
        enable   = 1'b1;
        req      = 4'b0000;
        req_code = 8'h00;

        repeat (2) @(negedge clk);
        checkOutput("reset_mute", 32'(mute), 32'd1);
        checkOutput("reset_code", 32'(code_sound), 32'd0);
        checkOutput("reset_grant", 32'(grant), 32'd0);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        clr = 1'b0;
        waitCycles(2);

        $display("[TB] simultaneous requests");
        applyStimulus(4'b1111, {SND_STOP, SND_GO, SND_PONG, SND_PING}, c);
        expectGrant(4'b0001, SND_PING, c + 2);
        expectGrant(4'b0010, SND_PONG, c + 13);
        expectGrant(4'b0100, SND_GO,   c + 24);
        expectGrant(4'b1000, SND_STOP, c + 35);
        waitCycles(50);

        $display("[TB] single event and tone window");
        applyStimulus(4'b0001, {6'd0, SND_PONG}, c);
        expectGrant(4'b0001, SND_PONG, c + 2);
        for (int o = 1; o <= 12; o++) begin
            @(negedge clk);
            checkOutput($sformatf("single_mute_c%0d", o), 32'(mute),
                        (o >= 2 && o <= 9) ? 32'd0 : 32'd1);
            checkOutput($sformatf("single_busy_c%0d", o), 32'(busy),
                        (o >= 2 && o <= 11) ? 32'd1 : 32'd0);
            if (o >= 2)
                checkOutput($sformatf("single_code_c%0d", o), 32'(code_sound), 32'd1);
        end
        waitCycles(3);

        $display("[TB] overwrite while busy");
        applyStimulus(4'b0010, {4'd0, SND_PING, 2'd0}, c);
        expectGrant(4'b0010, SND_PING, c + 2);
        applyStimulus(4'b0100, {2'd0, SND_GO, 4'd0}, c2);
        applyStimulus(4'b0100, {2'd0, SND_STOP, 4'd0}, c2);
        expectGrant(4'b0100, SND_STOP, c + 13);
        waitCycles(25);

        $display("[TB] set beats clear");
        @(posedge clk);
        #1;
        req      = 4'b0001;
        req_code = {6'd0, SND_PONG};
        c        = cyc;
        @(posedge clk);
        #1;
        req_code = {6'd0, SND_GO};
        @(posedge clk);
        #1;
        req = 4'b0000;
        expectGrant(4'b0001, SND_PONG, c + 2);
        expectGrant(4'b0001, SND_GO,   c + 13);
        waitCycles(25);

        $display("[TB] disable during tone");
        applyStimulus(4'b1000, {SND_STOP, 6'd0}, c);
        expectGrant(4'b1000, SND_STOP, c + 2);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        req      = 4'b0001;
        req_code = {6'd0, SND_GO};
        @(posedge clk);
        #1;
        req      = 4'b0010;
        req_code = {4'd0, SND_PONG, 2'd0};
        enable   = 1'b0;
        @(negedge clk);
        checkOutput("disable_mute_before", 32'(mute), 32'd0);
        checkOutput("disable_busy_before", 32'(busy), 32'd1);
        @(posedge clk);
        #1;
        req = 4'b0000;
        @(negedge clk);
        checkOutput("disable_mute_after", 32'(mute), 32'd1);
        checkOutput("disable_busy_after", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        req = 4'b0100;
        @(posedge clk);
        #1;
        req    = 4'b0000;
        enable = 1'b1;
        anyBusy = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            anyBusy = anyBusy | busy;
        end
        checkOutput("disable_discarded", 32'(anyBusy), 32'd0);
        waitCycles(2);

        $display("[TB] asynchronous reset mid-tone");
        applyStimulus(4'b0100, {2'd0, SND_GO, 4'd0}, c);
        expectGrant(4'b0100, SND_GO, c + 2);
        repeat (4) @(posedge clk);
        #3;
        clr = 1'b1;
        #1;
        checkOutput("areset_mute", 32'(mute), 32'd1);
        checkOutput("areset_grant", 32'(grant), 32'd0);
        checkOutput("areset_code", 32'(code_sound), 32'd0);
        checkOutput("areset_busy", 32'(busy), 32'd0);
        @(posedge clk);
        #2;
        clr = 1'b0;
        applyStimulus(4'b1001, {SND_STOP, 4'd0, SND_PONG}, c);
        expectGrant(4'b0001, SND_PONG, c + 2);
        expectGrant(4'b1000, SND_STOP, c + 13);
        waitCycles(30);

        checkOutput("queue_empty", 32'(expQ.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
